result_writeback: RTL

- Downstream stage of the compute engine. Collects fp16 results (conv/maxpool/avepool outputs) from the engine one per handshake.
- Packs two results into each 32-bit word and buffers the words in an internal FIFO.
- Streams the words to the DMA write channel with valid/ready flow control.
- Signals done once op_num results have been written back.

---
 rtl/result_writeback.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/result_writeback.sv
// result_writeback: collects fp16 engine results, packs two per 32-bit word,
// buffers the words in a FIFO and streams them to the DMA write channel.
// Optional feature macro: RESULT_RELU_EN (negative results forced to zero
// before packing).
module result_writeback #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_start,
    input  logic [31:0]       op_num,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result,
    output logic              result_ready,
    output logic              dma_wr_valid,
    output logic [31:0]       dma_wr_data,
    input  logic              dma_wr_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Control state
    logic [1:0]        state_q, state_d;
    logic [31:0]       op_num_q, op_num_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] half_q, half_d;
    logic              half_full_q, half_full_d;

    // FIFO state
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Datapath helpers
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic [DATA_W-1:0] res_w;
    logic [31:0]       cnt_inc;
    logic              last;

    // Result conditioning; the ReLU variant is purely combinational
`ifdef RESULT_RELU_EN
    assign res_w = result[DATA_W-1] ? '0 : result;
`else
    assign res_w = result;
`endif

    // FIFO status and handshakes; result_ready is intentionally combinational
    assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign result_ready = (state_q == S_COLLECT) && !fifo_full;
    assign accept       = result_valid && result_ready;
    assign dma_wr_valid = !fifo_empty;
    assign dma_wr_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign pop          = dma_wr_valid && dma_wr_ready;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign cnt_inc      = cnt_q + 32'd1;
    assign last         = accept && (cnt_inc == op_num_q);

    // Next-state, packing and push decode
    always_comb begin
        state_d     = state_q;
        op_num_d    = op_num_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        half_full_d = half_full_q;
        push        = 1'b0;
        push_data   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    if (op_num != 32'd0) begin
                        op_num_d    = op_num;
                        cnt_d       = '0;
                        half_d      = '0;
                        half_full_d = 1'b0;
                        state_d     = S_COLLECT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (half_full_q) begin
                        push        = 1'b1;
                        push_data   = WORD_W'({res_w, half_q});
                        half_full_d = 1'b0;
                    end else if (last) begin
                        // odd total: close the final word with a zero upper half
                        push        = 1'b1;
                        push_data   = WORD_W'(res_w);
                        half_full_d = 1'b0;
                    end else begin
                        half_d      = res_w;
                        half_full_d = 1'b1;
                    end
                    if (last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // finish as soon as the last buffered word leaves
                if (fifo_empty || (pop && (count_q == CNT_W'(1)))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update; push+pop leaves the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_num_q    <= '0;
            cnt_q       <= '0;
            half_q      <= '0;
            half_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_num_q    <= op_num_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            half_full_q <= half_full_d;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
